// File: rtl/mole_spawner.sv
// mole_spawner: round FSM, seconds countdown and pseudo-random LED target generation.
// Latency: game_start one cycle after start is sampled; first led_request SPAWN_CYCLES after game_start.
// Backpressure: none; requests are fire-and-forget single-cycle pulses, start is ignored while running.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   start        start/restart request, sampled every cycle (ignored while running)
//   led_index    target LED index 0..17, held between requests
//   led_request  one-cycle pulse, led_index valid in the same cycle
//   game_active  high while the round is running
//   game_start   one-cycle pulse on entry to a round
//   time_left    seconds remaining in the round
module mole_spawner #(
  parameter int          CLK_PERIOD_NS     = 50,
  parameter int          SPAWN_INTERVAL_MS = 1000,
  parameter int          GAME_TIME_SEC     = 30,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [4:0] led_index,
  output logic       led_request,
  output logic       game_active,
  output logic       game_start,
  output logic [6:0] time_left
);

  // Cycle counts derived from the clock period; computed wide to avoid overflow.
  localparam longint SEC_CYCLES   = longint'(1_000_000_000) / longint'(CLK_PERIOD_NS);
  localparam longint SPAWN_CYCLES = (longint'(SPAWN_INTERVAL_MS) * longint'(1_000_000))
                                    / longint'(CLK_PERIOD_NS);
  localparam logic [31:0] SEC_LAST   = 32'(SEC_CYCLES - 1);
  localparam logic [31:0] SPAWN_LAST = 32'(SPAWN_CYCLES - 1);

  localparam logic [6:0]  ROUND_SECS = 7'(GAME_TIME_SEC);
  localparam logic [4:0]  NUM_LEDS   = 5'd18;
  localparam logic [4:0]  LAST_LED   = 5'd17;

  // An all-zero Galois LFSR never leaves zero, so a zero seed is replaced.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] TAPS = 16'hB400;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q,       state_d;
  logic [15:0] lfsr_q,        lfsr_d;
  logic [31:0] sec_cnt_q,     sec_cnt_d;
  logic [31:0] spawn_cnt_q,   spawn_cnt_d;
  logic [6:0]  time_left_q,   time_left_d;
  logic [4:0]  led_index_q,   led_index_d;
  logic        led_request_q, led_request_d;
  logic        game_active_q, game_active_d;
  logic        game_start_q,  game_start_d;
  logic [4:0]  last_index_q,  last_index_d;
  logic        last_valid_q,  last_valid_d;

  // Target selection from the current LFSR state.
  logic [4:0] lfsr_low;
  logic [4:0] cand;
  logic [4:0] pick;

  // Timing events inside a running round.
  logic sec_tick;
  logic spawn_wrap;
  logic final_tick;

  always_comb begin
    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 16'h0000);
  end

  always_comb begin
    lfsr_low = lfsr_q[4:0];
    // Values 18..31 fold down to 0..13, keeping every result in 0..17.
    cand = (lfsr_low < NUM_LEDS) ? lfsr_low : (lfsr_low - NUM_LEDS);
    pick = cand;
    // Never repeat the previous target within a round; step to the next LED instead.
    if (last_valid_q && (cand == last_index_q)) begin
      pick = (cand == LAST_LED) ? 5'd0 : (cand + 5'd1);
    end
  end

  always_comb begin
    sec_tick   = (sec_cnt_q == SEC_LAST);
    spawn_wrap = (spawn_cnt_q == SPAWN_LAST);
    final_tick = sec_tick && (time_left_q == 7'd1);
  end

  always_comb begin
    state_d       = state_q;
    sec_cnt_d     = sec_cnt_q;
    spawn_cnt_d   = spawn_cnt_q;
    time_left_d   = time_left_q;
    led_index_d   = led_index_q;
    led_request_d = 1'b0;
    game_active_d = game_active_q;
    game_start_d  = 1'b0;
    last_index_d  = last_index_q;
    last_valid_d  = last_valid_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        sec_cnt_d     = 32'd0;
        spawn_cnt_d   = 32'd0;
        game_active_d = 1'b0;
        if (start) begin
          state_d       = S_RUN;
          game_start_d  = 1'b1;
          game_active_d = 1'b1;
          time_left_d   = ROUND_SECS;
          last_valid_d  = 1'b0;
        end
      end

      S_RUN: begin
        sec_cnt_d   = sec_tick   ? 32'd0 : (sec_cnt_q + 32'd1);
        spawn_cnt_d = spawn_wrap ? 32'd0 : (spawn_cnt_q + 32'd1);

        if (final_tick) begin
          // Round ends on this edge; a coincident spawn wrap is dropped.
          state_d       = S_DONE;
          time_left_d   = 7'd0;
          game_active_d = 1'b0;
          sec_cnt_d     = 32'd0;
          spawn_cnt_d   = 32'd0;
        end else begin
          if (sec_tick) begin
            time_left_d = time_left_q - 7'd1;
          end
          if (spawn_wrap) begin
            led_request_d = 1'b1;
            led_index_d   = pick;
            last_index_d  = pick;
            last_valid_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d       = S_IDLE;
        sec_cnt_d     = 32'd0;
        spawn_cnt_d   = 32'd0;
        game_active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      lfsr_q        <= SEED;
      sec_cnt_q     <= 32'd0;
      spawn_cnt_q   <= 32'd0;
      time_left_q   <= 7'd0;
      led_index_q   <= 5'd0;
      led_request_q <= 1'b0;
      game_active_q <= 1'b0;
      game_start_q  <= 1'b0;
      last_index_q  <= 5'd0;
      last_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      sec_cnt_q     <= sec_cnt_d;
      spawn_cnt_q   <= spawn_cnt_d;
      time_left_q   <= time_left_d;
      led_index_q   <= led_index_d;
      led_request_q <= led_request_d;
      game_active_q <= game_active_d;
      game_start_q  <= game_start_d;
      last_index_q  <= last_index_d;
      last_valid_q  <= last_valid_d;
    end
  end

  assign led_index   = led_index_q;
  assign led_request = led_request_q;
  assign game_active = game_active_q;
  assign game_start  = game_start_q;
  assign time_left   = time_left_q;

endmodule

// File: tb/tb_mole_spawner.sv
// tb_mole_spawner: directed round sequence with a request scoreboard for mole_spawner.
// Latency: expected requests are queued when start is driven and retired on the cycle they must appear.
// Backpressure: not applicable; the bench only observes output pulses.
module tb_mole_spawner;

  localparam int          SEC_C   = 1000;
  localparam int          SPAWN_C = 5;
  localparam int          GT      = 3;
  localparam int          NREQ    = (GT * SEC_C) / SPAWN_C - 1;
  localparam logic [15:0] SEED_A  = 16'hACE1;
  localparam logic [15:0] SEED_0  = 16'h0001;

  typedef struct {
    int         cyc;
    logic [4:0] idx;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] led_index;
  logic       led_request;
  logic       game_active;
  logic       game_start;
  logic [6:0] time_left;
  logic [4:0] led_index0;
  logic       led_request0;
  logic       game_active0;
  logic       game_start0;
  logic [6:0] time_left0;

  mole_spawner #(
    .CLK_PERIOD_NS    (1_000_000),
    .SPAWN_INTERVAL_MS(5),
    .GAME_TIME_SEC    (3),
    .LFSR_SEED        (16'hACE1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .led_index  (led_index),
    .led_request(led_request),
    .game_active(game_active),
    .game_start (game_start),
    .time_left  (time_left)
  );

  mole_spawner #(
    .CLK_PERIOD_NS    (1_000_000),
    .SPAWN_INTERVAL_MS(5),
    .GAME_TIME_SEC    (3),
    .LFSR_SEED        (16'h0000)
  ) dut0 (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .led_index  (led_index0),
    .led_request(led_request0),
    .game_active(game_active0),
    .game_start (game_start0),
    .time_left  (time_left0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors;
  int          checks;
  int          cyc_n;
  int          req_count;
  int          e;
  logic [15:0] lfsr_m;
  logic [15:0] lfsr0_m;
  exp_t        q[$];
  logic        have_prev;
  logic [4:0]  prev_idx;
  logic [4:0]  exp0[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp_v, cyc_n);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [4:0] cand_of(input logic [15:0] l);
    logic [4:0] v;
    v = l[4:0];
    return (v < 5'd18) ? v : (v - 5'd18);
  endfunction

  function automatic logic [4:0] avoid(input logic [4:0] c, input logic lv, input logic [4:0] last);
    if (lv && c == last) return (c == 5'd17) ? 5'd0 : (c + 5'd1);
    return c;
  endfunction

  // Called at a negedge just before the posedge that samples start=1.
  task automatic push_round();
    logic [15:0] l;
    logic [4:0]  last;
    logic        lv;
    logic [4:0]  c;
    exp_t        x;
    l    = lfsr_m;
    last = 5'd0;
    lv   = 1'b0;
    q.delete();
    have_prev = 1'b0;
    req_count = 0;
    for (int j = 1; j <= NREQ * SPAWN_C; j++) begin
      l = lfsr_step(l);
      if (j % SPAWN_C == 0) begin
        c     = avoid(cand_of(l), lv, last);
        x.cyc = cyc_n + 1 + j;
        x.idx = c;
        q.push_back(x);
        last = c;
        lv   = 1'b1;
      end
    end
  endtask

  // One clock: advance the LFSR models, then retire or reject requests.
  task automatic cycle();
    @(negedge clk);
    lfsr_m  = lfsr_step(lfsr_m);
    lfsr0_m = lfsr_step(lfsr0_m);
    cyc_n++;
    if (q.size() != 0 && q[0].cyc == cyc_n) begin
      chk("req_pulse", 32'(led_request), 32'd1);
      chk("req_index", 32'(led_index), 32'(q[0].idx));
      chk("idx_range", 32'(led_index < 5'd18), 32'd1);
      if (have_prev) chk("idx_repeat", 32'(led_index != prev_idx), 32'd1);
      have_prev = 1'b1;
      prev_idx  = led_index;
      req_count++;
      void'(q.pop_front());
    end else begin
      chk("no_req", 32'(led_request), 32'd0);
    end
  endtask

  task automatic run_to(input int target);
    while (cyc_n < target) cycle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_idx"},    32'(led_index),   32'd0);
    chk({tag, "_req"},    32'(led_request), 32'd0);
    chk({tag, "_active"}, 32'(game_active), 32'd0);
    chk({tag, "_gstart"}, 32'(game_start),  32'd0);
    chk({tag, "_time"},   32'(time_left),   32'd0);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    cyc_n     = 0;
    req_count = 0;
    have_prev = 1'b0;
    prev_idx  = 5'd0;
    rst       = 1'b1;
    start     = 1'b0;
    lfsr_m    = SEED_A;
    lfsr0_m   = SEED_0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Idle: no activity without start.
    repeat (2000) cycle();
    chk("idle_active", 32'(game_active), 32'd0);
    chk("idle_time", 32'(time_left), 32'd0);

    // Round 1: single-cycle start pulse.
    start = 1'b1;
    push_round();
    cycle();
    start = 1'b0;
    e = cyc_n;
    chk("gstart_hi", 32'(game_start), 32'd1);
    chk("start_time", 32'(time_left), 32'd3);
    chk("start_active", 32'(game_active), 32'd1);
    cycle();
    chk("gstart_lo", 32'(game_start), 32'd0);

    run_to(e + 999);
    chk("time_3", 32'(time_left), 32'd3);
    cycle();
    chk("time_2", 32'(time_left), 32'd2);

    // Start while running must not disturb the countdown or spawn phase.
    run_to(e + 1500);
    start = 1'b1;
    repeat (3) cycle();
    start = 1'b0;

    run_to(e + 1999);
    chk("time_2_end", 32'(time_left), 32'd2);
    cycle();
    chk("time_1", 32'(time_left), 32'd1);
    run_to(e + 2999);
    chk("pre_end_active", 32'(game_active), 32'd1);
    chk("pre_end_time", 32'(time_left), 32'd1);
    cycle();
    chk("end_time", 32'(time_left), 32'd0);
    chk("end_active", 32'(game_active), 32'd0);
    chk("end_req", 32'(led_request), 32'd0);
    chk("req_total", 32'(req_count), 32'(NREQ));
    chk("queue_drained", 32'(q.size()), 32'd0);

    // DONE holds quietly, then restart.
    repeat (20) cycle();
    chk("done_time", 32'(time_left), 32'd0);
    chk("done_active", 32'(game_active), 32'd0);
    start = 1'b1;
    push_round();
    cycle();
    start = 1'b0;
    e = cyc_n;
    chk("restart_gstart", 32'(game_start), 32'd1);
    chk("restart_time", 32'(time_left), 32'd3);

    // Asynchronous reset with the spawn counter between 2 and 3.
    run_to(e + 502);
    #2 rst = 1'b1;
    #1 chk_all_zero("arst");
    q.delete();
    lfsr_m  = SEED_A;
    lfsr0_m = SEED_0;
    @(negedge clk);
    rst = 1'b0;
    repeat (50) cycle();
    chk("post_rst_active", 32'(game_active), 32'd0);
    chk("post_rst_time", 32'(time_left), 32'd0);

    // Fresh round after reset; the zero-seed instance must behave as seed 1.
    begin
      logic [15:0] l;
      logic [4:0]  c;
      l = lfsr0_m;
      for (int j = 1; j <= 2 * SPAWN_C; j++) begin
        l = lfsr_step(l);
        if (j == SPAWN_C) exp0[0] = cand_of(l);
        if (j == 2 * SPAWN_C) begin
          c = cand_of(l);
          exp0[1] = avoid(c, 1'b1, exp0[0]);
        end
      end
    end
    start = 1'b1;
    push_round();
    cycle();
    start = 1'b0;
    e = cyc_n;
    run_to(e + SPAWN_C);
    chk("seed0_req1", 32'(led_request0), 32'd1);
    chk("seed0_idx1", 32'(led_index0), 32'(exp0[0]));
    run_to(e + 2 * SPAWN_C);
    chk("seed0_req2", 32'(led_request0), 32'd1);
    chk("seed0_idx2", 32'(led_index0), 32'(exp0[1]));
    run_to(e + 40);
    chk("seed_req_count", 32'(req_count), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mole_spawner.md
Name: mole_spawner

Overview:
Game-control and target-generation stage that sits directly upstream of the LED/switch scoring block. It runs the round state machine (idle, running, done) and counts down the round time in seconds. While a round is running, it issues a pseudo-random LED index with a one-cycle request pulse at a fixed spawn interval. It also pulses game_start so downstream logic can clear its per-round state.

Parameters:
CLK_PERIOD_NS, 50, clock period in ns; all cycle counts derive from it
SPAWN_INTERVAL_MS, 1000, time between LED requests while running
GAME_TIME_SEC, 30, round length in seconds; legal range 1..127
LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
start  input  1  synchronous start/restart request (level or pulse; sampled each cycle)
led_index  output  5  target LED index, always 0..17
led_request  output  1  one-cycle pulse; led_index valid in the same cycle
game_active  output  1  high while state is RUNNING
game_start  output  1  one-cycle pulse on entry to RUNNING
time_left  output  7  seconds remaining in the round

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Derived constants:
  - SEC_CYCLES = 1_000_000_000 / CLK_PERIOD_NS
  - SPAWN_CYCLES = SPAWN_INTERVAL_MS * 1_000_000 / CLK_PERIOD_NS
  - Use 32-bit counters.
- Reset values: state=IDLE, led_index=0, led_request=0, game_active=0, game_start=0, time_left=0, lfsr=seed, both counters=0, last_valid=0.
- LFSR:
  - 16-bit Galois, right shift.
  - next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Advances every cycle in every state, so the start timing seeds the sequence.
- Candidate index:
  - c = lfsr[4:0] when lfsr[4:0] < 18, else lfsr[4:0] - 18.
  - Both branches give 0..17.
- Repeat avoidance:
  - If last_valid and c == last_index, output c+1, wrapping 17 to 0.
  - On each request, record last_index and set last_valid=1.
  - last_valid is cleared on entry to RUNNING.
- FSM transitions:
  - IDLE: start=1 -> RUNNING.
  - RUNNING: start is ignored. On the final second tick (time_left==1 and sec counter==SEC_CYCLES-1) -> DONE.
  - DONE: start=1 -> RUNNING (restart).
- Entry to RUNNING, registered:
  - game_start=1 for exactly one cycle.
  - game_active=1.
  - time_left=GAME_TIME_SEC.
  - sec counter=0, spawn counter=0.
- Spawn timing:
  - The spawn counter increments each RUNNING cycle.
  - When it equals SPAWN_CYCLES-1: it wraps to 0, and on the next edge led_request=1 with the new led_index.
  - The first request therefore lands SPAWN_CYCLES cycles after game_start.
  - led_index holds its value between requests.
- Second tick:
  - The sec counter counts the same way.
  - On wrap, time_left decrements.
- Round end:
  - On the final tick, time_left becomes 0, game_active falls, and the state goes to DONE, all in one edge.
  - If a spawn wrap coincides with the final tick, the tick wins and no request is issued.
- No output activity in IDLE or DONE:
  - led_request=0, game_start=0.
  - time_left holds (0 after a round).
  - Counters are held at 0.
- Reset mid-round: everything returns immediately to reset values. No request may be issued until a new start.

Test Plan:
- Setup: all tests use CLK_PERIOD_NS=1_000_000 (SEC_CYCLES=1000), SPAWN_INTERVAL_MS=5 (SPAWN_CYCLES=5), GAME_TIME_SEC=3.
- Reset then idle: hold start=0 for 2000 cycles -> led_request never asserts; game_active=0; time_left=0.
- Start: 1-cycle start pulse -> game_start high for exactly 1 cycle and time_left=3. First led_request exactly 5 cycles after game_start, then every 5 cycles; each pulse is 1 cycle wide.
- Index legality: run a full round -> led_index<18 on every request; no two consecutive requests carry equal index; values match a bit-exact LFSR model.
- Countdown and end:
  - time_left reads 3,2,1 at 1000-cycle steps.
  - At cycle 3000 after entry, time_left=0, game_active=0, and no request in that cycle (3000 is a multiple of 5).
  - Exactly 599 requests in total.
- Start while running / restart from DONE: assert start mid-round -> no effect on time_left or spawn phase. Assert start in DONE -> new game_start, time_left=3, last_valid cleared.
- Async reset mid-round: assert rst between cycles 2 and 3 of a spawn interval -> all outputs 0 immediately with no further requests; the LFSR restarts from LFSR_SEED (verify LFSR_SEED=0 behaves as seed 1).
